// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Tracks a one-hot RED/GREEN/YELLOW light, counts full cycles and
//            flags illegal codes, out-of-order transitions and over-long dwell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int MAX_DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light,
    input  logic       clear_err,
    output logic [1:0] phase,
    output logic       locked,
    output logic [7:0] cycle_count,
    output logic       err_illegal,
    output logic       err_sequence,
    output logic       err_dwell,
    output logic       err_sticky
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } state_t;

    localparam logic [2:0] c_red       = 3'b100;
    localparam logic [2:0] c_green     = 3'b010;
    localparam logic [2:0] c_yellow    = 3'b001;
    localparam logic [3:0] c_max_dwell = 4'(MAX_DWELL);

    state_t     state_q, state_d;
    state_t     w_succ_state;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] cycle_q, cycle_d;
    logic       ill_q, ill_d;
    logic       seq_q, seq_d;
    logic       dwl_q, dwl_d;
    logic       sticky_q, sticky_d;
    logic [2:0] w_cur_code;
    logic [2:0] w_succ_code;
    logic       w_onehot;

    assign w_onehot = (light == c_red) || (light == c_green) || (light == c_yellow);

    // Code currently held and the only code allowed to follow it
    always_comb begin
        w_cur_code   = c_red;
        w_succ_code  = c_green;
        w_succ_state = ST_GREEN;
        case (state_q)
            ST_GREEN: begin
                w_cur_code   = c_green;
                w_succ_code  = c_yellow;
                w_succ_state = ST_YELLOW;
            end
            ST_YELLOW: begin
                w_cur_code   = c_yellow;
                w_succ_code  = c_red;
                w_succ_state = ST_RED;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cycle_d = cycle_q;
        ill_d   = 1'b0;
        seq_d   = 1'b0;
        dwl_d   = 1'b0;
        if (!w_onehot) begin
            ill_d   = 1'b1;
            state_d = ST_SYNC;
            dwell_d = 4'd0;
        end else if (state_q == ST_SYNC) begin
            if (light == c_red) begin
                state_d = ST_RED;
                dwell_d = 4'd1;
            end else begin
                dwell_d = 4'd0;
            end
        end else if (light == w_cur_code) begin
            dwell_d = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;
            dwl_d   = (dwell_q == c_max_dwell);
        end else if (light == w_succ_code) begin
            state_d = w_succ_state;
            dwell_d = 4'd1;
            if (state_q == ST_YELLOW) begin
                cycle_d = cycle_q + 8'd1;
            end
        end else begin
            seq_d   = 1'b1;
            state_d = ST_SYNC;
            dwell_d = 4'd0;
        end
        // A new error wins over a simultaneous clear
        sticky_d = (sticky_q & ~clear_err) | ill_d | seq_d | dwl_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            dwell_q  <= 4'd0;
            cycle_q  <= 8'd0;
            ill_q    <= 1'b0;
            seq_q    <= 1'b0;
            dwl_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            cycle_q  <= cycle_d;
            ill_q    <= ill_d;
            seq_q    <= seq_d;
            dwl_q    <= dwl_d;
            sticky_q <= sticky_d;
        end
    end

    assign phase        = state_q;
    assign locked       = (state_q != ST_SYNC);
    assign cycle_count  = cycle_q;
    assign err_illegal  = ill_q;
    assign err_sequence = seq_q;
    assign err_dwell    = dwl_q;
    assign err_sticky   = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Scoreboard bench for traffic_light_monitor with a phase/run model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    localparam int MAX_DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light = 3'b000;
    logic       clear_err = 1'b0;
    logic [1:0] phase;
    logic       locked;
    logic [7:0] cycle_count;
    logic       err_illegal;
    logic       err_sequence;
    logic       err_dwell;
    logic       err_sticky;

    traffic_light_monitor #(.MAX_DWELL(MAX_DWELL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .light        (light),
        .clear_err    (clear_err),
        .phase        (phase),
        .locked       (locked),
        .cycle_count  (cycle_count),
        .err_illegal  (err_illegal),
        .err_sequence (err_sequence),
        .err_dwell    (err_dwell),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    // Expected vector: {phase, locked, cycle_count, ill, seq, dwell, sticky}
    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: tracked phase (0 = unlocked), run length, cycle tally
    int m_trk = 0;
    int m_run = 0;
    int m_cyc = 0;
    bit m_st  = 0;

    function automatic int light2phase(input logic [2:0] l);
        case (l)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] phase2light(input int p);
        case (p)
            1:       return 3'b100;
            2:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic step(input logic [2:0] l, input logic clr, input logic rn);
        int p;
        bit ei, es, ed;
        @(negedge clk);
        light = l;
        clear_err = clr;
        rst_n = rn;
        ei = 0; es = 0; ed = 0;
        if (!rn) begin
            m_trk = 0; m_run = 0; m_cyc = 0; m_st = 0;
        end else begin
            p = light2phase(l);
            if (p == 0) begin
                ei = 1; m_trk = 0; m_run = 0;
            end else if (m_trk == 0) begin
                if (p == 1) begin m_trk = 1; m_run = 1; end
            end else if (p == m_trk) begin
                m_run = m_run + 1;
                ed = (m_run == MAX_DWELL + 1);
            end else if (p == (m_trk % 3) + 1) begin
                if (m_trk == 3) m_cyc = (m_cyc + 1) % 256;
                m_trk = p; m_run = 1;
            end else begin
                es = 1; m_trk = 0; m_run = 0;
            end
            m_st = (m_st && !clr) || ei || es || ed;
        end
        exp_q.push_back({2'(m_trk), (m_trk != 0), 8'(m_cyc), ei, es, ed, m_st});
    endtask

    task automatic rgy(input int n);
        for (int i = 0; i < n; i++) begin
            step(3'b100, 1'b0, 1'b1);
            step(3'b010, 1'b0, 1'b1);
            step(3'b001, 1'b0, 1'b1);
        end
    endtask

    // Monitor: every edge produces a registered response
    initial begin
        logic [14:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {phase, locked, cycle_count, err_illegal, err_sequence, err_dwell, err_sticky};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL outputs t=%0t: actual ph=%0d lk=%0b cnt=%0d ill=%0b seq=%0b dwl=%0b stk=%0b required ph=%0d lk=%0b cnt=%0d ill=%0b seq=%0b dwl=%0b stk=%0b",
                              $time, a[14:13], a[12], a[11:4], a[3], a[2], a[1], a[0],
                              e[14:13], e[12], e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, p;
        logic [2:0] l;
        step(3'b100, 1'b1, 1'b0);
        step(3'b111, 1'b0, 1'b0);
        // Three clean cycles
        rgy(3);
        // Illegal code while in RED, then relock
        step(3'b100, 1'b0, 1'b1);
        step(3'b110, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b1);
        // RED -> YELLOW sequence error, then long GREEN dwell
        step(3'b001, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b010, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b1);
        // Clear coinciding with a new error, then clear alone
        step(3'b001, 1'b1, 1'b1);
        step(3'b010, 1'b1, 1'b1);
        step(3'b010, 1'b0, 1'b1);
        // Reset while in GREEN with five completed cycles
        step(3'b100, 1'b0, 1'b0);
        rgy(5);
        step(3'b100, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b1);
        step(3'b010, 1'b1, 1'b0);
        step(3'b010, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b1);
        // Counter wrap
        step(3'b100, 1'b0, 1'b0);
        rgy(256);
        step(3'b100, 1'b0, 1'b1);
        // Random traffic biased towards legal progress
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            p = (m_trk == 0) ? 1 : m_trk;
            if (r == 0)      l = 3'($urandom_range(0, 7));
            else if (r == 1) l = phase2light($urandom_range(1, 3));
            else if (r < 7)  l = phase2light(p);
            else             l = phase2light((m_trk == 0) ? 1 : (m_trk % 3) + 1);
            step(l, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0));
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MAX_DWELL, default 4, meaning the maximum consecutive samples one light may hold before a dwell error; legal range 1..14.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the posedge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port light, input, 3 bits, the observed signal: RED=100, GREEN=010, YELLOW=001.
REQ-005 The block SHALL have port clear_err, input, 1 bit, which clears err_sticky.
REQ-006 The block SHALL have port phase, output, 2 bits, the decoded tracked light: 0=none/SYNC, 1=RED, 2=GREEN, 3=YELLOW.
REQ-007 The block SHALL have port locked, output, 1 bit, high while the FSM is in RED, GREEN or YELLOW.
REQ-008 The block SHALL have port cycle_count, output, 8 bits, the number of completed RED-GREEN-YELLOW-RED cycles.
REQ-009 The block SHALL have ports err_illegal, err_sequence and err_dwell, each an output of 1 bit, each a one-cycle error pulse.
REQ-010 The block SHALL have port err_sticky, output, 1 bit, the OR of all error pulses, held until cleared.

Function
REQ-011 The block SHALL sample light at every posedge; all outputs SHALL be registered and reflect the sample taken at that edge (1-cycle latency).
REQ-012 The FSM SHALL have states SYNC, RED, GREEN and YELLOW; phase and locked SHALL be decoded from the state.
REQ-013 In SYNC, a RED sample SHALL move the FSM to RED with dwell=1; GREEN and YELLOW samples SHALL be ignored, leaving it in SYNC with no error.
REQ-014 The only legal transitions SHALL be RED->GREEN, GREEN->YELLOW and YELLOW->RED; a repeat of the current light SHALL keep the state and increment dwell.
REQ-015 Any non-one-hot sample (000, 011, 101, 110, 111) SHALL pulse err_illegal and force SYNC, in any state.
REQ-016 A one-hot sample that is neither a repeat nor a legal successor in a locked state SHALL pulse err_sequence and force SYNC; examples are RED->YELLOW, GREEN->RED and YELLOW->GREEN.
REQ-017 An illegal code SHALL take priority over a sequence error; at most one of err_illegal or err_sequence SHALL pulse per cycle.
REQ-018 The dwell counter SHALL be 4 bits, reset to 1 on every legal transition, and saturate at 15.
REQ-019 err_dwell SHALL pulse exactly once, on the edge where dwell goes from MAX_DWELL to MAX_DWELL+1; the state SHALL be unchanged and tracking SHALL continue.
REQ-020 cycle_count SHALL increment by 1 on each YELLOW->RED transition and wrap from 255 to 0 without any flag.
REQ-021 The SYNC->RED entry SHALL NOT increment cycle_count.
REQ-022 cycle_count SHALL hold its value when the FSM falls back to SYNC.
REQ-023 err_sticky SHALL set on any error pulse and clear on clear_err; if clear_err and a new error occur on the same edge, err_sticky SHALL end up 1.
REQ-024 dwell SHALL NOT be incremented in SYNC and SHALL be forced to 0 there.

Reset
REQ-025 While rst_n=0 at a posedge, the block SHALL set state=SYNC, phase=0, locked=0, dwell=0, cycle_count=0, err_illegal=err_sequence=err_dwell=0 and err_sticky=0; the light sample SHALL be ignored.
REQ-026 Reset asserted mid-cycle SHALL discard the in-progress tracking; after release the block SHALL require a fresh RED to lock.
REQ-027 clear_err SHALL have no effect while rst_n=0.

Verification
REQ-028 Reset, then light RED,GREEN,YELLOW repeating one sample each for 9 cycles -> locked=1 after the first edge; phase 1,2,3 repeating; cycle_count=2; no errors.
REQ-029 Locked in RED, then light=110 -> err_illegal=1 for one cycle, phase=0, err_sticky=1; a following RED -> locked=1, cycle_count unchanged.
REQ-030 RED then YELLOW -> err_sequence=1 for one cycle and SYNC; with the same stimulus and MAX_DWELL=4, GREEN held 6 samples -> err_dwell high only on the 5th GREEN sample, phase stays 2.
REQ-031 Run 256 full cycles -> cycle_count wraps to 0 with no error.
REQ-032 clear_err=1 on the same edge as an err_sequence event -> err_sticky=1; clear_err alone on the next edge -> err_sticky=0.
REQ-033 rst_n=0 for one edge while in GREEN with cycle_count=5 -> all outputs 0; then GREEN,YELLOW -> remains SYNC with no errors; then RED -> locked=1.
